// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes seen by the control unit, reset constants
// and the fetch FSM state encoding.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        SKID  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction that was acked while decode was
// stalled. Flush beats load beats pop.
module fetch_skid_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pcplus4,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pcplus4,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_pcplus4;
    logic                  r_valid;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values;
    // the payload is reset as well since it is a single entry, not a RAM array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            r_pcplus4 <= '0;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_instr   <= i_instr;
            r_pcplus4 <= i_pcplus4;
            r_valid   <= 1'b1;
        end else if (i_pop) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: owns the PC, fetches over req/ack and loads IF/ID.
// Define IF_DELAY_SLOT_EN to keep the branch delay-slot instruction on redirect.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(PC_RESET_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectPC,
    output logic                  ImemReq,
    output logic [ADDR_WIDTH-1:0] ImemAddr,
    input  logic                  ImemAck,
    input  logic [DATA_WIDTH-1:0] ImemRdata,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [ADDR_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid
);

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS_EN = 1'b1;
`else
    localparam bit DS_EN = 1'b0;
`endif

    fetch_state_t          r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic [ADDR_WIDTH-1:0] r_req_addr, w_req_addr_next;
    logic                  r_pend, w_pend_next;
    logic [DATA_WIDTH-1:0] r_ifid_instr, w_ifid_instr_next;
    logic [ADDR_WIDTH-1:0] r_ifid_pcplus4, w_ifid_pcplus4_next;
    logic                  r_ifid_valid, w_ifid_valid_next;

    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic [ADDR_WIDTH-1:0] w_fetch_pcplus4;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic                  w_skid_load, w_skid_flush, w_skid_pop;
    logic [DATA_WIDTH-1:0] w_skid_instr;
    logic [ADDR_WIDTH-1:0] w_skid_pcplus4;
    logic                  w_skid_valid;
    logic                  w_unused_redirect_lsbs;

    // While a pre-redirect request is still in flight its address stays on the bus.
    assign w_fetch_addr    = r_pend ? r_req_addr : r_pc;
    assign w_fetch_pcplus4 = w_fetch_addr + ADDR_WIDTH'(4);
    assign w_redirect_pc   = {RedirectPC[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_redirect_lsbs = ^{RedirectPC[1:0], w_skid_valid};

    assign ImemReq          = (r_state == FETCH);
    assign ImemAddr         = w_fetch_addr;
    assign PC               = r_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_PCPlus4     = r_ifid_pcplus4;
    assign IFID_Valid       = r_ifid_valid;

    fetch_skid_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .i_load    (w_skid_load),
        .i_flush   (w_skid_flush),
        .i_pop     (w_skid_pop),
        .i_instr   (ImemRdata),
        .i_pcplus4 (w_fetch_pcplus4),
        .o_instr   (w_skid_instr),
        .o_pcplus4 (w_skid_pcplus4),
        .o_valid   (w_skid_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= RST;
            r_pc           <= PC_RESET;
            r_req_addr     <= PC_RESET;
            r_pend         <= 1'b0;
            r_ifid_instr   <= DATA_WIDTH'(NOP_INSTR);
            r_ifid_pcplus4 <= '0;
            r_ifid_valid   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_req_addr     <= w_req_addr_next;
            r_pend         <= w_pend_next;
            r_ifid_instr   <= w_ifid_instr_next;
            r_ifid_pcplus4 <= w_ifid_pcplus4_next;
            r_ifid_valid   <= w_ifid_valid_next;
        end
    end

    always_comb begin
        // NOTE: every next value defaults to "hold" first, so no branch can infer a latch.
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_req_addr_next     = r_req_addr;
        w_pend_next         = r_pend;
        w_ifid_instr_next   = r_ifid_instr;
        w_ifid_pcplus4_next = r_ifid_pcplus4;
        w_ifid_valid_next   = r_ifid_valid;
        w_skid_load         = 1'b0;
        w_skid_flush        = 1'b0;
        w_skid_pop          = 1'b0;

        case (r_state)
            RST: w_state_next = FETCH;

            FETCH: begin
                if (Redirect) begin
                    w_pc_next           = w_redirect_pc;
                    w_skid_flush        = 1'b1;
                    w_ifid_instr_next   = DATA_WIDTH'(NOP_INSTR);
                    w_ifid_pcplus4_next = '0;
                    w_ifid_valid_next   = 1'b0;
                    if (ImemAck) begin
                        w_pend_next = 1'b0;
                        if (DS_EN) begin
                            w_ifid_instr_next   = ImemRdata;
                            w_ifid_pcplus4_next = w_fetch_pcplus4;
                            w_ifid_valid_next   = 1'b1;
                        end
                    end else begin
                        w_pend_next     = 1'b1;
                        w_req_addr_next = w_fetch_addr;
                    end
                end else if (ImemAck) begin
                    w_pend_next = 1'b0;
                    // A stale pre-redirect response is dropped unless it is the delay slot.
                    if (!r_pend || DS_EN) begin
                        if (!r_pend) begin
                            w_pc_next = r_pc + ADDR_WIDTH'(4);
                        end
                        if (Stall) begin
                            w_skid_load  = 1'b1;
                            w_state_next = SKID;
                        end else begin
                            w_ifid_instr_next   = ImemRdata;
                            w_ifid_pcplus4_next = w_fetch_pcplus4;
                            w_ifid_valid_next   = 1'b1;
                        end
                    end
                end
            end

            SKID: begin
                if (Redirect) begin
                    w_pc_next           = w_redirect_pc;
                    w_skid_flush        = 1'b1;
                    w_state_next        = FETCH;
                    w_ifid_instr_next   = DS_EN ? w_skid_instr : DATA_WIDTH'(NOP_INSTR);
                    w_ifid_pcplus4_next = DS_EN ? w_skid_pcplus4 : '0;
                    w_ifid_valid_next   = DS_EN;
                end else if (!Stall) begin
                    w_skid_pop          = 1'b1;
                    w_state_next        = FETCH;
                    w_ifid_instr_next   = w_skid_instr;
                    w_ifid_pcplus4_next = w_skid_pcplus4;
                    w_ifid_valid_next   = 1'b1;
                end
            end

            default: w_state_next = RST;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: table of per-cycle vectors plus a fetch
// scoreboard. Expectations follow IF_DELAY_SLOT_EN when it is defined.
module tb_instruction_fetch_stage;
    import mips_pkg::*;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS_EN = 1'b1;
`else
    localparam bit DS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Redirect, ImemAck;
    logic [31:0] RedirectPC, ImemRdata;
    logic        ImemReq, IFID_Valid;
    logic [31:0] ImemAddr, PC, IFID_Instruction, IFID_PCPlus4;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .ImemReq          (ImemReq),
        .ImemAddr         (ImemAddr),
        .ImemAck          (ImemAck),
        .ImemRdata        (ImemRdata),
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        int          lat;
        bit          exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        bit          exp_valid;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    vec_t        vecs[26];
    int          mem_lat = 0;
    int          wait_cnt = 0;
    bit          tb_pend = 0;
    bit          tb_skid_v = 0;
    exp_t        tb_skid;
    logic [64:0] prev = '0;
    bit          obs_req;
    logic [31:0] obs_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0010) return {JAL, 26'h010_0040};
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        sb.push_back(e);
    endtask

    // One clock cycle: drive inputs and memory at the falling edge, observe after the rising edge.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc);
        bit          push_now;
        bit          changed;
        logic [64:0] cur;
        exp_t        e;
        @(negedge clk);
        Stall      = stall;
        Redirect   = redir;
        RedirectPC = rpc;
        obs_req    = ImemReq;
        obs_addr   = ImemAddr;
        if (ImemReq && wait_cnt >= mem_lat) begin
            ImemAck   = 1'b1;
            ImemRdata = mem_word(ImemAddr);
            wait_cnt  = 0;
        end else begin
            ImemAck   = 1'b0;
            ImemRdata = 32'hDEAD_BEEF;
            wait_cnt  = ImemReq ? wait_cnt + 1 : 0;
        end
        push_now = 1'b0;
        if (redir) begin
            if (ImemReq && ImemAck) begin
                if (DS_EN) begin
                    push_exp(mem_word(ImemAddr), ImemAddr + 32'd4);
                    push_now = 1'b1;
                end
                tb_pend = 1'b0;
            end else if (ImemReq) begin
                tb_pend = 1'b1;
            end
            if (tb_skid_v) begin
                if (DS_EN) begin
                    push_exp(tb_skid.instr, tb_skid.pc4);
                    push_now = 1'b1;
                end
                tb_skid_v = 1'b0;
            end
        end else if (ImemReq && ImemAck) begin
            if (!tb_pend || DS_EN) begin
                if (stall) begin
                    tb_skid.instr = mem_word(ImemAddr);
                    tb_skid.pc4   = ImemAddr + 32'd4;
                    tb_skid_v     = 1'b1;
                end else begin
                    push_exp(mem_word(ImemAddr), ImemAddr + 32'd4);
                    push_now = 1'b1;
                end
            end
            tb_pend = 1'b0;
        end else if (!ImemReq && tb_skid_v && !stall) begin
            push_exp(tb_skid.instr, tb_skid.pc4);
            push_now  = 1'b1;
            tb_skid_v = 1'b0;
        end

        @(posedge clk);
        #1;
        cur     = {IFID_Instruction, IFID_PCPlus4, IFID_Valid};
        changed = (cur !== prev);
        if (changed && IFID_Valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h expected=none", IFID_Instruction);
            end else begin
                e = sb.pop_front();
                check("sb_instr", IFID_Instruction, e.instr);
                check("sb_pc4", IFID_PCPlus4, e.pc4);
            end
        end else if (changed) begin
            check("bubble_instr", IFID_Instruction, NOP_INSTR);
            check("bubble_pc4", IFID_PCPlus4, 32'h0);
        end
        if (push_now) check("ifid_latency", 32'(changed), 32'd1);
        prev = cur;
    endtask

    // Holds reset for two cycles, checks reset values, releases just after a rising edge.
    task automatic do_reset();
        reset      = 1'b0;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = '0;
        ImemAck    = 1'b0;
        ImemRdata  = '0;
        wait_cnt   = 0;
        mem_lat    = 0;
        tb_pend    = 1'b0;
        tb_skid_v  = 1'b0;
        sb.delete();
        prev       = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_req", 32'(ImemReq), 32'd0);
        check("rst_addr", ImemAddr, PC_RESET_DEFAULT);
        check("rst_pc", PC, PC_RESET_DEFAULT);
        check("rst_instr", IFID_Instruction, NOP_INSTR);
        check("rst_pc4", IFID_PCPlus4, 32'h0);
        check("rst_valid", 32'(IFID_Valid), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;

        //            stall redir rpc            lat req  addr           pc after       valid after
        vecs[0]  = '{1'b0, 1'b0, 32'h0,          0, 1'b0, 32'h0040_0000, 32'h0040_0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0000, 32'h0040_0004, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0004, 32'h0040_0008, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0008, 32'h0040_000C, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,          0, 1'b1, 32'h0040_000C, 32'h0040_0010, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,          0, 1'b0, 32'h0040_0010, 32'h0040_0010, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,          0, 1'b0, 32'h0040_0010, 32'h0040_0010, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,          0, 1'b0, 32'h0040_0010, 32'h0040_0010, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0010, 32'h0040_0014, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,          2, 1'b1, 32'h0040_0014, 32'h0040_0014, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h0040_0101,  2, 1'b1, 32'h0040_0014, 32'h0040_0100, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,          2, 1'b1, 32'h0040_0014, 32'h0040_0100, DS_EN};
        vecs[12] = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0100, 32'h0040_0104, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0104, 32'h0040_0108, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 32'h0040_0200,  0, 1'b0, 32'h0040_0108, 32'h0040_0200, DS_EN};
        vecs[15] = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0200, 32'h0040_0204, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 32'h0040_0300,  0, 1'b1, 32'h0040_0204, 32'h0040_0300, DS_EN};
        vecs[17] = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0300, 32'h0040_0304, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  0, 1'b1, 32'h0040_0304, 32'hFFFF_FFFC, DS_EN};
        vecs[19] = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 32'h0,          3, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 32'h0040_0400,  3, 1'b1, 32'h0000_0004, 32'h0040_0400, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 32'h0040_0500,  3, 1'b1, 32'h0000_0004, 32'h0040_0500, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 32'h0,          3, 1'b1, 32'h0000_0004, 32'h0040_0500, DS_EN};
        vecs[25] = '{1'b0, 1'b0, 32'h0,          0, 1'b1, 32'h0040_0500, 32'h0040_0504, 1'b1};

        do_reset();
        for (int i = 0; i < 26; i++) begin
            mem_lat = vecs[i].lat;
            cycle(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check($sformatf("v%0d_req", i), 32'(obs_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), obs_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
            check($sformatf("v%0d_valid", i), 32'(IFID_Valid), 32'(vecs[i].exp_valid));
        end
        check("sb_drain_table", 32'(sb.size()), 32'd0);

        // JAL at 0x00400010 resolved in decode while 0x00400014 is being fetched.
        do_reset();
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (IFID_Instruction[31:26] == JAL) found = 1'b1;
        end
        check("jal_seen", 32'(found), 32'd1);
        check("jal_pc4", IFID_PCPlus4, 32'h0040_0014);
        cycle(1'b0, 1'b1, 32'h0040_0100);
        check("slot_addr", obs_addr, 32'h0040_0014);
        check("slot_valid", 32'(IFID_Valid), 32'(DS_EN));
        check("slot_pc", PC, 32'h0040_0100);
        cycle(1'b0, 1'b0, 32'h0);
        check("target_addr", obs_addr, 32'h0040_0100);
        check("target_pc4", IFID_PCPlus4, 32'h0040_0104);
        check("sb_drain_jal", 32'(sb.size()), 32'd0);

        // Reset pulled low mid-request, then a clean restart from PC_RESET.
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        check("pre_rst_pc", PC, 32'h0040_000C);
        mem_lat = 5;
        cycle(1'b0, 1'b0, 32'h0);
        check("pre_rst_req", 32'(ImemReq), 32'd1);
        #2;
        reset    = 1'b0;
        ImemAck  = 1'b0;
        wait_cnt = 0;
        #1;
        check("async_req", 32'(ImemReq), 32'd0);
        check("async_addr", ImemAddr, PC_RESET_DEFAULT);
        check("async_pc", PC, PC_RESET_DEFAULT);
        check("async_instr", IFID_Instruction, NOP_INSTR);
        check("async_pc4", IFID_PCPlus4, 32'h0);
        check("async_valid", 32'(IFID_Valid), 32'd0);
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        check("restart_rst_req", 32'(obs_req), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("restart_req", 32'(obs_req), 32'd1);
        check("restart_addr", obs_addr, PC_RESET_DEFAULT);
        check("restart_pc", PC, 32'h0040_0004);
        check("sb_drain_end", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
